// File: rtl/multicycle_control_fsm_pkg.sv
// multicycle_control_fsm_pkg: state, opcode and datapath-select encodings shared by the multi-cycle control slice
package multicycle_pkg;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5,
        S_ERR  = 3'd6
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] SRC_B_RS2  = 2'd0;
    localparam logic [1:0] SRC_B_IMM  = 2'd1;
    localparam logic [1:0] SRC_B_FOUR = 2'd2;

    localparam logic [1:0] PC_PLUS4     = 2'd0;
    localparam logic [1:0] PC_ALU       = 2'd1;
    localparam logic [1:0] PC_ALU_ALIGN = 2'd2;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;

    function automatic logic is_legal(input logic [6:0] op);
        return op inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR};
    endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// multicycle_control_fsm_if: request/ready handshake between the control FSM and the shared memory
interface multicycle_control_fsm_if;
    logic mem_read;
    logic mem_write;
    logic i_or_d;
    logic mem_ready;
    modport master (output mem_read, mem_write, i_or_d, input mem_ready);
    modport slave (input mem_read, mem_write, i_or_d, output mem_ready);
endinterface

// File: rtl/multicycle_control_fsm_mem_wait_timer.sv
// mem_wait_timer: counts stalled memory-wait cycles and flags the cycle on which the wait limit expires
module mem_wait_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic active,
    input  logic ready,
    output logic expire
);
    localparam int W = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [W-1:0] LIM = W'(TIMEOUT_CYCLES == 0 ? 0 : TIMEOUT_CYCLES - 1);
    logic [W-1:0] cnt;
    // count while a request is outstanding and unanswered; any other cycle restarts the count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt <= '0;
        else cnt <= (active && !ready) ? cnt + W'(1) : '0;
    end
    assign expire = (TIMEOUT_CYCLES != 0) && active && !ready && (cnt == LIM);
endmodule

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: IF/ID/EX/MEM/WB sequencer for the multi-cycle RV32I core; CSED_MC_PERF_CNT_EN adds perf counters
module multicycle_control_fsm
    import multicycle_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
`ifdef CSED_MC_PERF_CNT_EN
    , parameter int CNT_W = 32
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       is_ecall_inst,
    input  logic       alu_bcond,
    multicycle_control_fsm_if.master mem,
    output logic       ir_write,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       pc_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_mode,
    output logic       pc_write,
    output logic [1:0] pc_source,
    output logic [2:0] state_out,
    output logic       mem_timeout,
`ifdef CSED_MC_PERF_CNT_EN
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retired_cnt,
`endif
    output logic       is_halted
);
    state_t state, next;
    logic expire;

    mem_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk(clk),
        .reset(reset),
        .active(state == S_IF || state == S_MEM),
        .ready(mem.mem_ready),
        .expire(expire)
    );

    // state register and sticky timeout flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IF;
            mem_timeout <= 1'b0;
        end else begin
            state <= next;
            if (expire) mem_timeout <= 1'b1;
        end
    end

    // next state and Moore decode; strobes are masked while reset is held low
    always_comb begin
        next = state;
        mem.mem_read = 1'b0;
        mem.mem_write = 1'b0;
        mem.i_or_d = 1'b0;
        ir_write = 1'b0;
        reg_write = 1'b0;
        mem_to_reg = 1'b0;
        pc_to_reg = 1'b0;
        alu_src_a = 1'b0;
        alu_src_b = SRC_B_RS2;
        alu_mode = ALU_ADD;
        pc_write = 1'b0;
        pc_source = PC_PLUS4;
        case (state)
            S_IF: begin
                mem.mem_read = 1'b1;
                ir_write = mem.mem_ready;
                next = expire ? S_ERR : mem.mem_ready ? S_ID : S_IF;
            end
            S_ID: begin
                alu_src_b = SRC_B_IMM;
                next = is_ecall_inst ? S_HALT : is_legal(opcode) ? S_EX : S_ERR;
            end
            S_EX: begin
                case (opcode)
                    OP_R: begin
                        alu_src_a = 1'b1;
                        alu_mode = ALU_FUNCT;
                        next = S_WB;
                    end
                    OP_I: begin
                        alu_src_a = 1'b1;
                        alu_src_b = SRC_B_IMM;
                        alu_mode = ALU_FUNCT;
                        next = S_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_src_a = 1'b1;
                        alu_src_b = SRC_B_IMM;
                        next = S_MEM;
                    end
                    OP_BRANCH: begin
                        alu_src_a = 1'b1;
                        alu_mode = ALU_SUB;
                        pc_write = 1'b1;
                        pc_source = alu_bcond ? PC_ALU : PC_PLUS4;
                        next = S_IF;
                    end
                    OP_JAL: begin
                        alu_src_b = SRC_B_IMM;
                        next = S_WB;
                    end
                    OP_JALR: begin
                        alu_src_a = 1'b1;
                        alu_src_b = SRC_B_IMM;
                        next = S_WB;
                    end
                    default: next = S_ERR;
                endcase
            end
            S_MEM: begin
                mem.i_or_d = 1'b1;
                mem.mem_read = opcode == OP_LOAD;
                mem.mem_write = opcode == OP_STORE;
                pc_write = opcode == OP_STORE && mem.mem_ready;
                next = expire ? S_ERR : !mem.mem_ready ? S_MEM : opcode == OP_LOAD ? S_WB : S_IF;
            end
            S_WB: begin
                reg_write = 1'b1;
                pc_write = 1'b1;
                mem_to_reg = opcode == OP_LOAD;
                pc_to_reg = opcode == OP_JAL || opcode == OP_JALR;
                pc_source = opcode == OP_JAL ? PC_ALU : opcode == OP_JALR ? PC_ALU_ALIGN : PC_PLUS4;
                next = S_IF;
            end
            default: next = state;
        endcase
        if (!reset) begin
            mem.mem_read = 1'b0;
            mem.mem_write = 1'b0;
            ir_write = 1'b0;
            reg_write = 1'b0;
            pc_write = 1'b0;
        end
    end

    assign state_out = state;
    assign is_halted = state == S_HALT || state == S_ERR;

`ifdef CSED_MC_PERF_CNT_EN
    // saturating live-cycle and retired-instruction counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_cnt <= '0;
            retired_cnt <= '0;
        end else begin
            if (!is_halted && !(&cycle_cnt)) cycle_cnt <= cycle_cnt + 1'b1;
            if (pc_write && !(&retired_cnt)) retired_cnt <= retired_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: randomized instruction traces checked against a phase-level model of the control sequence
module tb_multicycle_control_fsm;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [6:0] opcode = 7'b0110011;
    logic is_ecall_inst = 1'b0;
    logic alu_bcond = 1'b0;
    logic ir_write, reg_write, mem_to_reg, pc_to_reg, alu_src_a, pc_write, mem_timeout, is_halted;
    logic [1:0] alu_src_b, alu_mode, pc_source;
    logic [2:0] state_out;
`ifdef CSED_MC_PERF_CNT_EN
    logic [31:0] cycle_cnt, retired_cnt;
`endif

    multicycle_control_fsm_if mif ();

    multicycle_control_fsm #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk),
        .reset(reset),
        .opcode(opcode),
        .is_ecall_inst(is_ecall_inst),
        .alu_bcond(alu_bcond),
        .mem(mif.master),
        .ir_write(ir_write),
        .reg_write(reg_write),
        .mem_to_reg(mem_to_reg),
        .pc_to_reg(pc_to_reg),
        .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b),
        .alu_mode(alu_mode),
        .pc_write(pc_write),
        .pc_source(pc_source),
        .state_out(state_out),
        .mem_timeout(mem_timeout),
`ifdef CSED_MC_PERF_CNT_EN
        .cycle_cnt(cycle_cnt),
        .retired_cnt(retired_cnt),
`endif
        .is_halted(is_halted)
    );

    always #5 clk = ~clk;

    localparam int R = 0, I = 1, LD = 2, ST = 3, BR = 4, JAL = 5, JALR = 6;
    localparam logic [6:0] OPS [7] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                       7'b1100011, 7'b1101111, 7'b1100111};

    typedef struct {
        logic rdy;
        logic [14:0] exp;
        logic [14:0] msk;
        bit alu_chk;
        logic [4:0] alu;
    } step_t;

    step_t q[$];
    int checks = 0;
    int failures = 0;
    logic [14:0] obs_vec;
    logic [4:0] obs_alu;
    assign obs_vec = {state_out, is_halted, mem_timeout, mif.mem_read, mif.mem_write, mif.i_or_d,
                      ir_write, reg_write, mem_to_reg, pc_to_reg, pc_write, pc_source};
    assign obs_alu = {alu_src_a, alu_src_b, alu_mode};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input bit rdy, input int st, input bit rd, input bit wr, input bit iod,
                        input bit irw, input bit rw, input bit m2r, input bit p2r, input bit pcw,
                        input int pcs, input bit hal, input bit tmo, input bit ac, input logic [4:0] alu);
        step_t s;
        logic [2:0] st3;
        logic [1:0] pc2;
        st3 = st[2:0];
        pc2 = pcs[1:0];
        s.rdy = rdy;
        s.exp = {st3, hal, tmo, rd, wr, iod, irw, rw, m2r, p2r, pcw, pc2};
        s.msk = '1;
        if (!(rd || wr)) s.msk[7] = 1'b0;
        if (!pcw) s.msk[1:0] = 2'b00;
        s.alu_chk = ac;
        s.alu = alu;
        q.push_back(s);
    endtask

    task automatic push_idle(input int st, input bit hal, input bit tmo);
        push(1'($urandom % 2), st, 0, 0, 0, 0, 0, 0, 0, 0, 0, hal, tmo, 0, 5'd0);
    endtask

    task automatic push_fetch(input int d1);
        for (int k = 0; k < d1; k++) push(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0);
        push(1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0);
    endtask

    task automatic gen(input int c, input int d1, input int d2, input bit bc);
        bit ldst;
        opcode = OPS[c];
        is_ecall_inst = 1'b0;
        alu_bcond = bc;
        ldst = c == LD || c == ST;
        push_fetch(d1);
        push_idle(1, 0, 0);
        if (c == BR) push(1'($urandom % 2), 2, 0, 0, 0, 0, 0, 0, 0, 1, int'(bc), 0, 0, 1, 5'b1_00_01);
        else if (c == R) push(1'($urandom % 2), 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b1_00_10);
        else if (c == I) push(1'($urandom % 2), 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b1_01_10);
        else if (ldst) push(1'($urandom % 2), 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b1_01_00);
        else push_idle(2, 0, 0);
        if (ldst) begin
            for (int k = 0; k < d2; k++) push(0, 3, c == LD, c == ST, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0);
            push(1, 3, c == LD, c == ST, 1, 0, 0, 0, 0, c == ST, 0, 0, 0, 0, 5'd0);
        end
        if (c != BR && c != ST)
            push(1'($urandom % 2), 4, 0, 0, 0, 0, 1, c == LD, c == JAL || c == JALR, 1,
                 c == JAL ? 1 : c == JALR ? 2 : 0, 0, 0, 0, 5'd0);
    endtask

    task automatic run(input string tag);
        step_t s;
        int n = 0;
        while (q.size() > 0) begin
            s = q.pop_front();
            mif.mem_ready = s.rdy;
            #1;
            chk($sformatf("%s_c%0d", tag, n), 32'(obs_vec & s.msk), 32'(s.exp & s.msk));
            if (s.alu_chk) chk($sformatf("%s_alu_c%0d", tag, n), 32'(obs_alu), 32'(s.alu));
            @(negedge clk);
            n++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk(tag, 32'(obs_vec), 32'd0);
`ifdef CSED_MC_PERF_CNT_EN
        chk({tag, "_cycle_cnt"}, cycle_cnt, 32'd0);
        chk({tag, "_retired_cnt"}, retired_cnt, 32'd0);
`endif
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b0;
        mif.mem_ready = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs(tag);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        logic [6:0] bad;
        int d1;
        mif.mem_ready = 1'b0;
        do_reset("reset_init");

        gen(R, 0, 0, 0);
        run("r_add_ready1");
        gen(LD, 0, 3, 0);
        run("load_mem_wait3");
        gen(BR, 0, 0, 1);
        run("branch_taken");
        gen(BR, 0, 0, 0);
        run("branch_not_taken");
        gen(LD, 3, 3, 0);
        run("ready_on_limit_edge");

        for (int k = 0; k < 40; k++) begin
            gen(int'($urandom_range(0, 6)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom % 2));
            run($sformatf("rand%0d", k));
        end

        for (int k = 0; k < 4; k++) push(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0);
        for (int k = 0; k < 3; k++) push_idle(6, 1, 1);
        run("timeout_if");
        do_reset("reset_after_if_timeout");

        d1 = int'($urandom_range(0, 3));
        gen(LD, d1, 0, 0);
        while (q.size() > d1 + 3) void'(q.pop_back());
        for (int k = 0; k < 4; k++) push(0, 3, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0);
        for (int k = 0; k < 3; k++) push_idle(6, 1, 1);
        run("timeout_mem");
        do_reset("reset_after_mem_timeout");

        bad = 7'($urandom);
        while (bad inside {OPS[0], OPS[1], OPS[2], OPS[3], OPS[4], OPS[5], OPS[6]}) bad = 7'($urandom);
        opcode = bad;
        push_fetch(1);
        push_idle(1, 0, 0);
        for (int k = 0; k < 5; k++) push_idle(6, 1, 0);
        run("illegal_opcode");
        do_reset("reset_after_illegal");

        opcode = 7'b1110011;
        is_ecall_inst = 1'b1;
        push_fetch(int'($urandom_range(0, 3)));
        push_idle(1, 0, 0);
        for (int k = 0; k < 100; k++) push_idle(5, 1, 0);
        run("ecall_halt");
        do_reset("reset_after_halt");
        is_ecall_inst = 1'b0;
        gen(I, 0, 0, 0);
        run("resume_after_halt");

        d1 = int'($urandom_range(0, 3));
        gen(ST, d1, 3, 0);
        while (q.size() > d1 + 3) void'(q.pop_back());
        run("store_to_mem");
        mif.mem_ready = 1'b0;
        #1;
        chk("store_mem_write_before_reset", 32'(mif.mem_write), 32'd1);
        #1;
        reset = 1'b0;
        #1;
        check_reset_outputs("store_async_reset");
        @(posedge clk);
        #1;
        check_reset_outputs("store_reset_held");
        @(negedge clk);
        reset = 1'b1;
        gen(R, 0, 0, 0);
        run("after_store_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Control state machine for the multi-cycle RV32I core. Replaces the single-cycle control_unit plus hardwired PC update.
- Sequences IF/ID/EX/MEM/WB over a shared variable-latency memory using a ready handshake.
- Drives datapath mux selects and write strobes, detects ecall/illegal opcodes, and guards memory waits with a timeout.

Parameters:
- TIMEOUT_CYCLES, 16, max cycles to wait for mem_ready in IF/MEM before error; 0 disables the timeout.
- CNT_W, 32, width of performance counters (only used with the optional feature).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- opcode  input  7  instruction[6:0] from IR; valid from ID onward
- is_ecall_inst  input  1  IR matches ecall encoding
- alu_bcond  input  1  branch condition from ALU, valid in EX
- mem_ready  input  1  memory completes current read/write this cycle
- mem_read  output  1  memory read request, held until accepted
- mem_write  output  1  memory write request, held until accepted
- i_or_d  output  1  0 = PC addresses memory, 1 = ALUOut
- ir_write  output  1  load IR from memory dout
- reg_write  output  1  register file write enable
- mem_to_reg  output  1  1 = MDR to rd, 0 = ALUOut
- pc_to_reg  output  1  1 = PC+4 to rd (jal/jalr)
- alu_src_a  output  1  0 = PC, 1 = rs1
- alu_src_b  output  2  0 = rs2, 1 = imm, 2 = constant 4
- alu_mode  output  2  0 = add, 1 = sub/compare (branch), 2 = funct-decoded
- pc_write  output  1  PC update strobe
- pc_source  output  2  0 = PC+4, 1 = ALU result, 2 = ALU result & ~1
- state_out  output  3  current state encoding (debug)
- is_halted  output  1  sticky halt
- mem_timeout  output  1  sticky; set when a memory wait times out

Behaviour:
- States: IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5, ERR=6. Outputs are Moore, decoded from state and opcode.
- Reset (reset=0, asynchronous): state=IF, wait counter=0, is_halted=0, mem_timeout=0. All strobes and requests forced 0 while reset=0.
- IF:
  - mem_read=1, i_or_d=0, held until mem_ready=1.
  - On that edge: ir_write=1 (same cycle), go to ID.
- ID:
  - is_ecall_inst → HALT.
  - Opcode not in {R, I-ALU, LOAD, STORE, BRANCH, JAL, JALR} → ERR.
  - Otherwise → EX.
- EX by opcode:
  - R: alu_src_a=1, alu_src_b=0, alu_mode=2 → WB.
  - I-ALU: alu_src_a=1, alu_src_b=1, alu_mode=2 → WB.
  - LOAD/STORE: alu_src_a=1, alu_src_b=1, alu_mode=0 → MEM.
  - BRANCH: alu_src_a=1, alu_src_b=0, alu_mode=1, pc_write=1. pc_source=1 if alu_bcond else 0. ALU target computed from ALUOut latched in ID (PC+imm) → IF.
  - JAL/JALR: target into ALUOut → WB.
- MEM:
  - i_or_d=1; mem_read=1 (LOAD) or mem_write=1 (STORE), held until mem_ready.
  - LOAD → WB. STORE → pc_write=1, pc_source=0 → IF.
- WB:
  - reg_write=1, pc_write=1.
  - mem_to_reg=1 for LOAD; pc_to_reg=1 for JAL/JALR.
  - pc_source: 0 for R/I/LOAD, 1 for JAL, 2 for JALR → IF.
- Minimum latencies with mem_ready tied 1: branch 3, R/I/store/jal/jalr 4, load 5 cycles.
- Wait counter:
  - Cleared on entry to IF/MEM; increments each cycle the request is outstanding and mem_ready=0.
  - When count reaches TIMEOUT_CYCLES (and TIMEOUT_CYCLES≠0): → ERR, mem_timeout=1, request dropped.
  - mem_ready arriving on the same edge as the limit wins (no timeout).
- mem_ready outside IF/MEM is ignored.
- HALT and ERR are absorbing: all strobes 0. is_halted=1 in both.
- Reset asserted mid-instruction aborts immediately; no partial register or PC write occurs after reset assertion.

Optional Feature:
- Macro CSED_MC_PERF_CNT_EN.
- Defined:
  - Extra outputs cycle_cnt[CNT_W-1:0] (counts every cycle not in HALT/ERR) and retired_cnt[CNT_W-1:0] (increments on each pc_write).
  - Both reset to 0 and saturate at all-ones.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Package multicycle_pkg:
  - state enum typedef.
  - RV32I opcode constants (R=0110011, I=0010011, LOAD=0000011, STORE=0100011, BRANCH=1100011, JAL=1101111, JALR=1100111).
  - alu_src_b, pc_source and alu_mode encodings.
- One natural sub-module: mem_wait_timer (wait counter + timeout compare), instantiated once.

Test Plan:
- Reset then R-type add, mem_ready tied 1 → states IF,ID,EX,WB; reg_write and pc_write=1 only in cycle 4, pc_source=0.
- Load with mem_ready delayed 3 cycles in MEM → mem_read held 4 cycles, i_or_d=1; WB follows with mem_to_reg=1; total 8 cycles.
- Branch, alu_bcond=1 then 0 → both take 3 cycles; pc_write=1 in EX with pc_source=1 and 0 respectively.
- TIMEOUT_CYCLES=4, mem_ready stuck 0 in IF → ERR after 4 waiting cycles; mem_timeout=1, is_halted=1, mem_read=0 afterwards.
- ecall in ID → HALT next cycle; is_halted stays 1 for 100 cycles; reset low then high → state IF, is_halted=0.
- Reset pulsed low during MEM of a store → mem_write drops asynchronously, no pc_write; with CSED_MC_PERF_CNT_EN both counters read 0.
